// File: rtl/logic_gate_unit.sv
// Registered, parametrised bitwise logic unit: applies one of eight gate functions
// and can left-fold it across a multi-beat valid/ready packet.
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CNT_W-1:0] out_count
);

    // Handshake: a beat moves when in_valid && in_ready, a result when
    // out_valid && out_ready; in_ready = !out_valid || out_ready in every state.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] fold_y;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             load;

    function automatic logic [WIDTH-1:0] apply_op(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    always_comb begin
        in_ready   = !out_valid || out_ready;
        accept     = in_valid && in_ready;
        load       = accept && in_last;
        state_next = state;
        if (state == IDLE) begin
            fold_y   = apply_op(in_op, in_a, in_b);
            cnt_next = CNT_W'(1);
        end else begin
            // Mid-packet the left operand is the running fold and the op is latched.
            fold_y   = apply_op(op_q, acc, in_b);
            cnt_next = (&cnt) ? cnt : cnt + CNT_W'(1);
        end
        if (accept) begin
            state_next = in_last ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_count <= '0;
        end else begin
            if (accept) begin
                acc <= fold_y;
                cnt <= cnt_next;
                if (state == IDLE) begin
                    op_q <= in_op;
                end
            end
            // A new result may replace one transferring this cycle, keeping full throughput.
            if (load) begin
                out_y     <= fold_y;
                out_count <= cnt_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// Bench for logic_gate_unit: directed scenarios plus randomized packets checked
// against a packet-level fold model through an expected-result queue.
module tb_logic_gate_unit;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [2:0]    in_op;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [CW-1:0] out_count;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [W-1:0]  s_in_a;
    logic [W-1:0]  s_in_b;
    logic [2:0]    s_in_op;
    logic          s_in_last;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [W-1:0]  s_out_y;
    logic [1:0]    s_out_count;

    int n_vec;
    int n_err;
    bit rand_bp;

    logic [W+CW-1:0] exp_q[$];
    logic [W-1:0]    pkt_b[$];
    logic [W-1:0]    pkt_a;
    logic [2:0]      pkt_op;

    logic [W-1:0] tbl[8] = '{8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC, 8'h33};

    logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_count(out_count)
    );

    logic_gate_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_last(s_in_last),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_y(s_out_y), .out_count(s_out_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the gate rules applied to whole packets
    function automatic logic [W-1:0] ref_f(input logic [2:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        case (op)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x;
            default: return ~x;
        endcase
    endfunction

    task automatic model_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2:0] op, input logic last);
        logic [W-1:0] y;
        int           n;
        if (pkt_b.size() == 0) begin
            pkt_a  = a;
            pkt_op = op;
        end
        pkt_b.push_back(b);
        if (last) begin
            y = pkt_a;
            for (int i = 0; i < pkt_b.size(); i++) y = ref_f(pkt_op, y, pkt_b[i]);
            n = (pkt_b.size() > 255) ? 255 : pkt_b.size();
            exp_q.push_back({y, CW'(n)});
            pkt_b.delete();
        end
    endtask

    // Scoreboard: every result transfer must match the head of the expected queue
    always begin
        logic [W+CW-1:0] e;
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got y=%h count=%0d, required no result", out_y, out_count);
            end else begin
                e = exp_q.pop_front();
                if ({out_y, out_count} !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got y=%h count=%0d, required y=%h count=%0d",
                             out_y, out_count, e[W+CW-1:CW], e[CW-1:0]);
                end
            end
        end
    end

    // Driver: called at a negedge, returns at the negedge after acceptance
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] op, input logic last);
        int n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_last  = last;
        #1;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL beat_timeout: in_ready=%b, required 1 within 60 cycles", in_ready);
        end else begin
            model_beat(a, b, op, last);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_op = '0; s_in_last = 1'b0;
        s_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, out_y, out_count, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b y=%h c=%0d rdy=%b, required v=0 y=00 c=0 rdy=1",
                     out_valid, out_y, out_count, in_ready);
        end
    endtask

    task automatic test_single_ops();
        for (int op = 0; op < 8; op++) begin
            send_beat(8'hCC, 8'hAA, 3'(op), 1'b1);
            n_vec++;
            if ({out_valid, out_y, out_count} !== {1'b1, tbl[op], 8'd1}) begin
                n_err++;
                $display("FAIL single_op%0d: got v=%b y=%h c=%0d, required v=1 y=%h c=1",
                         op, out_valid, out_y, out_count, tbl[op]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_packets();
        send_beat(8'hFF, 8'hF0, 3'd0, 1'b0);
        send_beat(8'h00, 8'h3C, 3'd0, 1'b0);
        send_beat(8'h00, 8'h0F, 3'd0, 1'b1);
        n_vec++;
        if ({out_valid, out_y, out_count} !== {1'b1, 8'h00, 8'd3}) begin
            n_err++;
            $display("FAIL and_packet: got v=%b y=%h c=%0d, required v=1 y=00 c=3", out_valid, out_y, out_count);
        end
        send_beat(8'h0F, 8'hF0, 3'd2, 1'b0);
        send_beat(8'h00, 8'hFF, 3'd2, 1'b0);
        send_beat(8'h00, 8'h5A, 3'd2, 1'b1);
        n_vec++;
        if ({out_valid, out_y, out_count} !== {1'b1, 8'h5A, 8'd3}) begin
            n_err++;
            $display("FAIL xor_packet: got v=%b y=%h c=%0d, required v=1 y=5a c=3", out_valid, out_y, out_count);
        end
        send_beat(8'hFF, 8'hFF, 3'd3, 1'b0);
        send_beat(8'h12, 8'h00, 3'd1, 1'b1);
        n_vec++;
        if ({out_valid, out_y, out_count} !== {1'b1, 8'hFF, 8'd2}) begin
            n_err++;
            $display("FAIL nand_ignore_op: got v=%b y=%h c=%0d, required v=1 y=ff c=2", out_valid, out_y, out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_beat(8'hCC, 8'hAA, 3'd0, 1'b1);
        in_valid = 1'b1; in_a = 8'hCC; in_b = 8'hAA; in_op = 3'd1; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if ({in_ready, out_valid, out_y, out_count} !== {1'b0, 1'b1, 8'h88, 8'd1}) begin
                n_err++;
                $display("FAIL stall_hold%0d: got rdy=%b v=%b y=%h c=%0d, required rdy=0 v=1 y=88 c=1",
                         i, in_ready, out_valid, out_y, out_count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got in_ready=%b, required 1", in_ready);
        end
        model_beat(8'hCC, 8'hAA, 3'd1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, out_y, out_count} !== {1'b1, 8'hEE, 8'd1}) begin
            n_err++;
            $display("FAIL b2b_load: got v=%b y=%h c=%0d, required v=1 y=ee c=1", out_valid, out_y, out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        send_beat(8'hF0, 8'h0F, 3'd1, 1'b0);
        send_beat(8'h00, 8'h33, 3'd1, 1'b0);
        rst = 1'b1;
        pkt_b.delete();
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({out_valid, out_y, out_count, in_ready} !== {1'b0, 8'h00, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL mid_reset: got v=%b y=%h c=%0d rdy=%b, required v=0 y=00 c=0 rdy=1",
                     out_valid, out_y, out_count, in_ready);
        end
        send_beat(8'hF0, 8'h3C, 3'd0, 1'b1);
        n_vec++;
        if ({out_valid, out_y, out_count} !== {1'b1, 8'h30, 8'd1}) begin
            n_err++;
            $display("FAIL post_reset_beat: got v=%b y=%h c=%0d, required v=1 y=30 c=1", out_valid, out_y, out_count);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int len;
        logic [2:0] op;
        rand_bp = 1'b1;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 5);
            op  = 3'($urandom_range(0, 7));
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                send_beat(W'($urandom), W'($urandom),
                          (k == 0) ? op : 3'($urandom_range(0, 7)), (k == len - 1));
            end
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] y;
        y = 8'h00;
        for (int i = 0; i < 6; i++) begin
            s_in_valid = 1'b1; s_in_a = 8'h00; s_in_b = W'(1 << i); s_in_op = 3'd1;
            s_in_last = (i == 5);
            y = ref_f(3'd1, y, s_in_b);
            #1;
            if (!s_in_ready) begin
                n_vec++;
                n_err++;
                $display("FAIL sat_ready: got s_in_ready=%b, required 1", s_in_ready);
            end
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        n_vec++;
        if ({s_out_valid, s_out_y, s_out_count} !== {1'b1, y, 2'd3}) begin
            n_err++;
            $display("FAIL sat_count: got v=%b y=%h c=%0d, required v=1 y=%h c=3",
                     s_out_valid, s_out_y, s_out_count, y);
        end
        @(negedge clk);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rand_bp = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_ops();
        test_packets();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
